// File: rtl/regfile_wb_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_sequencer_pkg
//   Shared constants and types for the register-file write-back sequencer.
//   RF_* constants give the default geometry of the 32x32 register file and
//   the write-back FIFO. src_sel_t names the source that won arbitration.
// ---------------------------------------------------------------------------
package regfile_wb_sequencer_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DEPTH    = 4;
  localparam int RF_NUM_REGS = 1 << RF_ADDR_W;
  localparam int RF_CNT_W    = $clog2(RF_DEPTH) + 1;

  // Which producer, if any, completed a handshake this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_ALU  = 2'd2
  } src_sel_t;

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_sequencer_if
//   Bundles the producer handshakes (ALU results, load returns), the write
//   port toward the register file, and the hazard/occupancy status.
//   slave  : view used by the sequencer
//   master : view used by whoever drives producers and watches the write port
// ---------------------------------------------------------------------------
interface regfile_wb_sequencer_if
  import regfile_wb_sequencer_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) ();

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                alu_valid;
  logic                alu_ready;
  logic [ADDR_W-1:0]   alu_rd;
  logic [DATA_W-1:0]   alu_data;

  logic                ld_valid;
  logic                ld_ready;
  logic [ADDR_W-1:0]   ld_rd;
  logic [DATA_W-1:0]   ld_data;

  logic                wb_hold;

  logic                RegWrite;
  logic [ADDR_W-1:0]   Write_register;
  logic [DATA_W-1:0]   Write_data;

  logic [NUM_REGS-1:0] busy_mask;
  logic [CNT_W-1:0]    count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  wb_hold,
    output alu_ready, ld_ready,
    output RegWrite, Write_register, Write_data,
    output busy_mask, count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output wb_hold,
    input  alu_ready, ld_ready,
    input  RegWrite, Write_register, Write_data,
    input  busy_mask, count
  );

endinterface

// File: rtl/regfile_wb_sequencer_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   DEPTH-entry FIFO of {rd, data} pending register writes.
//   Ports:
//     clk, rst           clock, async active-high reset
//     push_i             enqueue {push_rd_i, push_data_i} (ignored when full)
//     pop_i              dequeue head (ignored when empty)
//     full_o, empty_o    occupancy flags
//     count_o            number of valid entries, 0..DEPTH
//     head_rd_o/data_o   entry at the read pointer
//     entry_valid_o      per-slot valid flag
//     entry_rd_o         per-slot destination register
// ---------------------------------------------------------------------------
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_rd_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [CNT_W-1:0]              count_o,
  output logic [ADDR_W-1:0]             head_rd_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [DEPTH-1:0]              entry_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_rd_o
);

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Guarding here keeps count inside 0..DEPTH whatever the caller does
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_rd_o     = rd_q[rd_ptr_q];
  assign head_data_o   = data_q[rd_ptr_q];
  assign entry_valid_o = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd_o[i] = rd_q[i];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // The pop clear is applied before the push set; they can only hit the same
  // slot when full or empty, and neither case allows both operations.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; slot validity is tracked by valid_q
  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_q[wr_ptr_q]   <= push_rd_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_wb_sequencer
//   Write side of the register file. Accepts ALU results and load returns,
//   queues them in wb_fifo and issues one register-file write per cycle.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-high reset
//     bus_io   regfile_wb_sequencer_if.slave:
//                alu_valid/ready/rd/data   ALU result handshake
//                ld_valid/ready/rd/data    load return handshake (priority)
//                wb_hold                   suppress issue this cycle
//                RegWrite/Write_register/Write_data  registered write port
//                busy_mask                 registers with a write in flight
//                count                     FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_wb_sequencer
  import regfile_wb_sequencer_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wb_sequencer_if.slave    bus_io
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                          full;
  logic                          empty;
  logic [CNT_W-1:0]              fifo_count;
  logic [ADDR_W-1:0]             head_rd;
  logic [DATA_W-1:0]             head_data;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]  entry_rd;

  logic                          ld_ready;
  logic                          alu_ready;
  src_sel_t                      src_sel;
  logic                          push;
  logic [ADDR_W-1:0]             push_rd;
  logic [DATA_W-1:0]             push_data;
  logic                          pop;

  logic                          RegWrite_q, RegWrite_d;
  logic [ADDR_W-1:0]             Write_register_q, Write_register_d;
  logic [DATA_W-1:0]             Write_data_q, Write_data_d;
  logic [NUM_REGS-1:0]           busy_mask;

  // Loads always win; ALU is only offered a slot when no load is waiting.
  // Ready is held low while reset is asserted so nothing is lost into a
  // FIFO that is being cleared.
  assign ld_ready  = !full && !rst;
  assign alu_ready = !full && !bus_io.ld_valid && !rst;

  // Pick the source that completed its handshake and decide whether it is
  // worth enqueueing; writes to x0 complete the handshake but are dropped.
  always_comb begin
    src_sel   = SRC_NONE;
    push      = 1'b0;
    push_rd   = '0;
    push_data = '0;
    if (bus_io.ld_valid && ld_ready) begin
      src_sel = SRC_LD;
    end else if (bus_io.alu_valid && alu_ready) begin
      src_sel = SRC_ALU;
    end
    case (src_sel)
      SRC_LD: begin
        push_rd   = bus_io.ld_rd;
        push_data = bus_io.ld_data;
        push      = (bus_io.ld_rd != '0);
      end
      SRC_ALU: begin
        push_rd   = bus_io.alu_rd;
        push_data = bus_io.alu_data;
        push      = (bus_io.alu_rd != '0);
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  assign pop = !empty && !bus_io.wb_hold;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_rd_i     (push_rd),
    .push_data_i   (push_data),
    .pop_i         (pop),
    .full_o        (full),
    .empty_o       (empty),
    .count_o       (fifo_count),
    .head_rd_o     (head_rd),
    .head_data_o   (head_data),
    .entry_valid_o (entry_valid),
    .entry_rd_o    (entry_rd)
  );

  // The write port pulses RegWrite for one cycle per popped entry; index and
  // data keep their last value when idle.
  always_comb begin
    RegWrite_d       = pop;
    Write_register_d = Write_register_q;
    Write_data_d     = Write_data_q;
    if (pop) begin
      Write_register_d = head_rd;
      Write_data_d     = head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite_q       <= 1'b0;
      Write_register_q <= '0;
      Write_data_q     <= '0;
    end else begin
      RegWrite_q       <= RegWrite_d;
      Write_register_q <= Write_register_d;
      Write_data_q     <= Write_data_d;
    end
  end

  // A register stays busy while any queued entry targets it or while its
  // write is on the port; the bit drops after the committing edge.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        busy_mask[entry_rd[i]] = 1'b1;
      end
    end
    if (RegWrite_q) begin
      busy_mask[Write_register_q] = 1'b1;
    end
  end

  assign bus_io.ld_ready       = ld_ready;
  assign bus_io.alu_ready      = alu_ready;
  assign bus_io.RegWrite       = RegWrite_q;
  assign bus_io.Write_register = Write_register_q;
  assign bus_io.Write_data     = Write_data_q;
  assign bus_io.busy_mask      = busy_mask;
  assign bus_io.count          = fifo_count;

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_sequencer
//   Drives the sequencer through reset, single writes, load priority, x0
//   drops, full-FIFO backpressure and reset-while-pending. Every accepted
//   non-x0 entry is pushed to a scoreboard queue; a negedge monitor pops and
//   compares each issued register-file write.
// ---------------------------------------------------------------------------
module tb_regfile_wb_sequencer;
  import regfile_wb_sequencer_pkg::*;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t expq[$];

  regfile_wb_sequencer_if bus ();

  regfile_wb_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write on the port must match the oldest
  // expected entry, and writes with nothing expected are errors
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.RegWrite === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_write got rd=%0d data=%h required no write",
                 bus.Write_register, bus.Write_data);
      end else begin
        e = expq.pop_front();
        if ({bus.Write_register, bus.Write_data} !== {e.rd, e.data}) begin
          errors++;
          $display("[TB] FAIL sb_write got rd=%0d data=%h required rd=%0d data=%h",
                   bus.Write_register, bus.Write_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    #12;
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_regwrite got %b required 0", bus.RegWrite); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL rst_count got %0d required 0", bus.count); end
    checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("[TB] FAIL rst_busy got %h required 0", bus.busy_mask); end
    checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b00) begin errors++; $display("[TB] FAIL rst_ready_held got %b required 00", {bus.ld_ready, bus.alu_ready}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL rst_release_ready got %b required 11", {bus.ld_ready, bus.alu_ready}); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL rst_release_count got %0d required 0", bus.count); end
    // Put a write on the port, then hit reset mid-cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h0000_1234;
    step();
    expq.push_back('{rd: 5'd6, data: 32'h0000_1234});
    idle_inputs();
    step();
    checks++; if ({bus.RegWrite, bus.Write_register} !== {1'b1, 5'd6}) begin errors++; $display("[TB] FAIL rst_pre_write got %b/%0d required 1/6", bus.RegWrite, bus.Write_register); end
    #2;
    rst = 1'b1;
    expq.delete();
    #1;
    checks++; if ({bus.RegWrite, bus.Write_register, bus.Write_data} !== {1'b0, 5'd0, 32'h0}) begin
      errors++; $display("[TB] FAIL rst_async_outputs got %b/%0d/%h required 0/0/0", bus.RegWrite, bus.Write_register, bus.Write_data);
    end
    checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("[TB] FAIL rst_async_busy got %h required 0", bus.busy_mask); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_alu();
    $display("[TB] test_single_alu");
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    step();
    expq.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
    idle_inputs();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL alu_latency got RegWrite=%b required 0", bus.RegWrite); end
    checks++; if (bus.busy_mask !== 32'h0000_0020) begin errors++; $display("[TB] FAIL alu_busy_queued got %h required 00000020", bus.busy_mask); end
    step();
    checks++; if ({bus.RegWrite, bus.Write_register, bus.Write_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL alu_write got %b/%0d/%h required 1/5/deadbeef", bus.RegWrite, bus.Write_register, bus.Write_data);
    end
    checks++; if (bus.busy_mask !== 32'h0000_0020) begin errors++; $display("[TB] FAIL alu_busy_issuing got %h required 00000020", bus.busy_mask); end
    step();
    checks++; if ({bus.RegWrite, bus.Write_register, bus.Write_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL alu_after got %b/%0d/%h required 0/5/deadbeef", bus.RegWrite, bus.Write_register, bus.Write_data);
    end
    checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("[TB] FAIL alu_busy_clear got %h required 0", bus.busy_mask); end
  endtask

  task automatic test_ld_priority();
    $display("[TB] test_ld_priority");
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd4; bus.ld_data  = 32'h22;
    #1;
    checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b10) begin errors++; $display("[TB] FAIL prio_ready got %b required 10", {bus.ld_ready, bus.alu_ready}); end
    step();
    expq.push_back('{rd: 5'd4, data: 32'h22});
    bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL prio_alu_ready got %b required 1", bus.alu_ready); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("[TB] FAIL prio_count got %0d required 1", bus.count); end
    step();
    expq.push_back('{rd: 5'd3, data: 32'h11});
    idle_inputs();
    checks++; if ({bus.RegWrite, bus.Write_register} !== {1'b1, 5'd4}) begin errors++; $display("[TB] FAIL prio_first got %b/%0d required 1/4", bus.RegWrite, bus.Write_register); end
    checks++; if (bus.busy_mask !== 32'h0000_0018) begin errors++; $display("[TB] FAIL prio_busy got %h required 00000018", bus.busy_mask); end
    step();
    checks++; if ({bus.RegWrite, bus.Write_register, bus.Write_data} !== {1'b1, 5'd3, 32'h11}) begin
      errors++; $display("[TB] FAIL prio_second got %b/%0d/%h required 1/3/11", bus.RegWrite, bus.Write_register, bus.Write_data);
    end
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle got %b required 0", bus.RegWrite); end
  endtask

  task automatic test_x0_drop();
    $display("[TB] test_x0_drop");
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hAAAA_5555;
    #1;
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_ld_ready got %b required 1", bus.ld_ready); end
    step();
    bus.ld_valid  = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5555_AAAA;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_alu_ready got %b required 1", bus.alu_ready); end
    step();
    idle_inputs();
    checks++; if ({bus.count, bus.busy_mask} !== {3'd0, 32'h0}) begin errors++; $display("[TB] FAIL x0_state got count=%0d busy=%h required 0/0", bus.count, bus.busy_mask); end
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL x0_no_write got %b required 0", bus.RegWrite); end
    step();
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    bus.wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(i); bus.ld_data = 32'hA000_0000 + 32'(i);
      step();
      expq.push_back('{rd: 5'(i), data: 32'hA000_0000 + 32'(i)});
    end
    idle_inputs();
    #1;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL full_count got %0d required 4", bus.count); end
    checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b00) begin errors++; $display("[TB] FAIL full_ready got %b required 00", {bus.ld_ready, bus.alu_ready}); end
    checks++; if (bus.busy_mask !== 32'h0000_001E) begin errors++; $display("[TB] FAIL full_busy got %h required 0000001e", bus.busy_mask); end
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL full_hold got %b required 0", bus.RegWrite); end
    bus.wb_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if ({bus.RegWrite, bus.Write_register} !== {1'b1, 5'(i)}) begin
        errors++; $display("[TB] FAIL drain_%0d got %b/%0d required 1/%0d", i, bus.RegWrite, bus.Write_register, i);
      end
      checks++; if (bus.count !== 3'(4 - i)) begin errors++; $display("[TB] FAIL drain_count_%0d got %0d required %0d", i, bus.count, 4 - i); end
      if (i == 1) begin
        checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL drain_ready got %b required 11", {bus.ld_ready, bus.alu_ready}); end
      end
    end
    step();
    checks++; if ({bus.RegWrite, bus.busy_mask} !== {1'b0, 32'h0}) begin errors++; $display("[TB] FAIL drain_done got %b/%h required 0/0", bus.RegWrite, bus.busy_mask); end
  endtask

  task automatic test_reset_discard();
    $display("[TB] test_reset_discard");
    bus.wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(7 + i); bus.ld_data = 32'hC0DE_0000 + 32'(i);
      step();
      expq.push_back('{rd: 5'(7 + i), data: 32'hC0DE_0000 + 32'(i)});
    end
    idle_inputs();
    checks++; if ({bus.count, bus.busy_mask} !== {3'd3, 32'h0000_0380}) begin
      errors++; $display("[TB] FAIL pend_state got count=%0d busy=%h required 3/00000380", bus.count, bus.busy_mask);
    end
    #2;
    rst = 1'b1;
    expq.delete();
    #1;
    checks++; if ({bus.RegWrite, bus.busy_mask, bus.count} !== {1'b0, 32'h0, 3'd0}) begin
      errors++; $display("[TB] FAIL pend_reset got %b/%h/%0d required 0/0/0", bus.RegWrite, bus.busy_mask, bus.count);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.wb_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL stale_write_%0d got %b required 0", i, bus.RegWrite); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.wb_hold = 1'b0;
    idle_inputs();
    test_reset();
    test_single_alu();
    test_ld_priority();
    test_x0_drop();
    test_back_to_back();
    test_reset_discard();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover got %0d entries required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
